// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives a single-outstanding instruction memory
// request, fills the IF/ID pipeline register, and handles stall, freeze and
// branch redirects (including draining a request that was in flight at the redirect).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Freeze,
    input  logic        Br_Taken,
    input  logic [31:0] Br_Addr,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic        IF_Valid,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] buf_q;        // instruction returned while the pipe was not advancing
    logic [31:0] drain_addr_q; // address of a squashed request still awaiting its ack
    logic        req_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] if_pc_q;

    logic        adv;
    logic        br;
    logic [31:0] pc_plus4;

    assign adv      = ~Stall & ~Freeze;
    assign br       = Br_Taken & ~Freeze;
    assign pc_plus4 = pc_q + 32'd4;

    // Fetch FSM with PC, IF/ID, hold buffer and drain address as registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            buf_q        <= 32'h0;
            drain_addr_q <= 32'h0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0;
            if_pc_q      <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                    if (br) begin
                        pc_q    <= Br_Addr;
                        valid_q <= 1'b0;
                    end
                end
                StFetch: begin
                    if (br) begin
                        pc_q    <= Br_Addr;
                        valid_q <= 1'b0;
                        // Request still outstanding: wait out its ack at the old address
                        if (!Imem_Ack) begin
                            drain_addr_q <= pc_q;
                            state_q      <= StDrain;
                        end
                    end else if (Imem_Ack) begin
                        if (adv) begin
                            instr_q <= Imem_Data;
                            if_pc_q <= pc_plus4;
                            valid_q <= 1'b1;
                            pc_q    <= pc_plus4;
                        end else begin
                            buf_q   <= Imem_Data;
                            state_q <= StHold;
                            req_q   <= 1'b0;
                        end
                    end else if (adv) begin
                        valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (br) begin
                        pc_q    <= Br_Addr;
                        valid_q <= 1'b0;
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end else if (adv) begin
                        instr_q <= buf_q;
                        if_pc_q <= pc_plus4;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4;
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end
                end
                StDrain: begin
                    // Latest redirect target wins; returned data is dropped
                    if (br) begin
                        pc_q    <= Br_Addr;
                        valid_q <= 1'b0;
                    end
                    if (Imem_Ack) begin
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Fetch address: the in-flight address while draining, otherwise the PC
    always_comb begin
        Imem_Addr = pc_q;
        if (state_q == StDrain) begin
            Imem_Addr = drain_addr_q;
        end
    end

    assign Imem_Req = req_q;
    assign IF_Valid = valid_q;
    assign IF_Instr = instr_q;
    assign IF_PC    = if_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level model of the fetch stage.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, freeze, br_taken, imem_ack;
    logic [31:0] br_addr, imem_data;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    int n_vec = 0;
    int n_err = 0;

    // Model state: fetch stage described as flags, not FSM states
    logic        m_active;      // first post-reset cycle done
    logic [31:0] m_pc;
    logic        m_have_buf;    // instruction captured, waiting for pipe to advance
    logic [31:0] m_buf;
    logic        m_squash;      // outstanding request whose data will be dropped
    logic [31:0] m_squash_addr;
    logic        m_valid;
    logic [31:0] m_instr, m_ifpc;

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(stall), .Freeze(freeze), .Br_Taken(br_taken),
        .Br_Addr(br_addr), .Imem_Req(imem_req), .Imem_Addr(imem_addr), .Imem_Ack(imem_ack),
        .Imem_Data(imem_data), .IF_Valid(if_valid), .IF_Instr(if_instr), .IF_PC(if_pc)
    );

    if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .Stall(stall), .Freeze(freeze), .Br_Taken(br_taken),
        .Br_Addr(br_addr), .Imem_Req(w_req), .Imem_Addr(w_addr), .Imem_Ack(imem_ack),
        .Imem_Data(imem_data), .IF_Valid(w_valid), .IF_Instr(w_instr), .IF_PC(w_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic exp_req();
        return m_active && !m_have_buf;
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_squash ? m_squash_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_pc = 32'h0; m_have_buf = 1'b0; m_buf = 32'h0;
        m_squash = 1'b0; m_squash_addr = 32'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0;
    endtask

    // Memory returns a word derived from the address the model expects
    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] ba,
                         input logic a);
        stall = s; freeze = f; br_taken = b; br_addr = ba; imem_ack = a;
        imem_data = mem_word(exp_addr());
    endtask

    // One clock: advance the model with the applied inputs, sample on the falling edge
    task automatic cycle();
        logic adv, br, act, hb, sq, v;
        logic [31:0] pc, bf, sqa, ins, ip;
        adv = !stall && !freeze;
        br  = br_taken && !freeze;
        act = m_active; pc = m_pc; hb = m_have_buf; bf = m_buf;
        sq = m_squash; sqa = m_squash_addr; v = m_valid; ins = m_instr; ip = m_ifpc;
        if (!act) begin
            act = 1'b1;
            if (br) begin pc = br_addr; v = 1'b0; end
        end else if (sq) begin
            if (br) begin pc = br_addr; v = 1'b0; end
            if (imem_ack) sq = 1'b0;
        end else if (hb) begin
            if (br) begin
                hb = 1'b0; pc = br_addr; v = 1'b0;
            end else if (adv) begin
                hb = 1'b0; ins = bf; ip = pc + 32'd4; v = 1'b1; pc = pc + 32'd4;
            end
        end else begin
            if (br) begin
                v = 1'b0;
                if (!imem_ack) begin sq = 1'b1; sqa = pc; end
                pc = br_addr;
            end else if (imem_ack) begin
                if (adv) begin
                    ins = imem_data; ip = pc + 32'd4; v = 1'b1; pc = pc + 32'd4;
                end else begin
                    hb = 1'b1; bf = imem_data;
                end
            end else if (adv) begin
                v = 1'b0;
            end
        end
        @(posedge clk);
        m_active = act; m_pc = pc; m_have_buf = hb; m_buf = bf;
        m_squash = sq; m_squash_addr = sqa; m_valid = v; m_instr = ins; m_ifpc = ip;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", if_instr); end
        n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_ifpc: got %h want 0", if_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 0);
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
        cycle();
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        n_vec++; if (w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first_addr: got %h want fffffffc", w_addr); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 32'h0, 1);
            cycle();
            n_vec++; if (if_pc !== 32'(4 * (i + 1))) begin n_err++; $display("FAIL zw_ifpc[%0d]: got %h want %h", i, if_pc, 32'(4 * (i + 1))); end
            n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d]: got %b want 1", i, if_valid); end
            n_vec++; if (if_instr !== mem_word(32'(4 * i))) begin n_err++; $display("FAIL zw_instr[%0d]: got %h want %h", i, if_instr, mem_word(32'(4 * i))); end
            if (i == 0) begin
                n_vec++; if (w_pc !== 32'h0) begin n_err++; $display("FAIL wrap_ifpc: got %h want 0", w_pc); end
                n_vec++; if (w_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next_addr: got %h want 0", w_addr); end
            end
        end
    endtask

    task automatic test_stall_hold();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 32'h0, (k == 0));
            cycle();
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d]: got %b want 0", k, imem_req); end
            n_vec++; if (if_pc !== 32'd16) begin n_err++; $display("FAIL hold_ifpc[%0d]: got %h want 10", k, if_pc); end
            n_vec++; if (if_instr !== mem_word(32'd12)) begin n_err++; $display("FAIL hold_instr[%0d]: got %h want %h", k, if_instr, mem_word(32'd12)); end
        end
        drive(0, 0, 0, 32'h0, 0);
        cycle();
        n_vec++; if (if_instr !== mem_word(32'd16)) begin n_err++; $display("FAIL unhold_instr: got %h want %h", if_instr, mem_word(32'd16)); end
        n_vec++; if (if_pc !== 32'd20) begin n_err++; $display("FAIL unhold_ifpc: got %h want 14", if_pc); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'd20) begin n_err++; $display("FAIL resume_addr: got %b/%h want 1/14", imem_req, imem_addr); end
    endtask

    task automatic test_branch_drain();
        drive(1, 0, 0, 32'h0, 0);
        cycle();
        n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_keep_valid: got %b want 1", if_valid); end
        drive(1, 0, 1, 32'h100, 0);
        cycle();
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", if_valid); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'd20) begin n_err++; $display("FAIL drain_addr: got %b/%h want 1/14", imem_req, imem_addr); end
        drive(0, 0, 0, 32'h0, 0);
        cycle();
        n_vec++; if (imem_addr !== 32'd20) begin n_err++; $display("FAIL drain_stable: got %h want 14", imem_addr); end
        drive(0, 0, 0, 32'h0, 1);
        cycle();
        n_vec++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redirect_addr: got %h want 100", imem_addr); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL drain_discard: got %b want 0", if_valid); end
        drive(0, 0, 0, 32'h0, 1);
        cycle();
        n_vec++; if (if_pc !== 32'h104 || if_instr !== mem_word(32'h100)) begin n_err++; $display("FAIL target_ifid: got %h/%h want 104/%h", if_pc, if_instr, mem_word(32'h100)); end
    endtask

    task automatic test_freeze();
        drive(0, 1, 1, 32'h200, 0);
        cycle();
        n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL freeze_no_flush: got %b want 1", if_valid); end
        n_vec++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL freeze_no_redirect: got %h want 104", imem_addr); end
        drive(0, 0, 1, 32'h200, 0);
        cycle();
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL unfreeze_flush: got %b want 0", if_valid); end
        drive(0, 0, 0, 32'h0, 1);
        cycle();
        n_vec++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL unfreeze_redirect: got %h want 200", imem_addr); end
    endtask

    task automatic test_reset_in_drain();
        drive(0, 0, 1, 32'h300, 0);
        cycle();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL pre_rst_drain: got %b/%h want 1/200", imem_req, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_rst_req: got %b want 0", imem_req); end
        n_vec++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin n_err++; $display("FAIL async_rst_ifid: got %b/%h/%h want 0/0/0", if_valid, if_instr, if_pc); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 1); // stray ack while idle
        cycle();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_req: got %b/%h want 1/0", imem_req, imem_addr); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stray_ack: got %b want 0", if_valid); end
    endtask

    task automatic test_random();
        logic s, f, b, a;
        logic [31:0] ba;
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom % 4 == 0);
            f  = ($urandom % 7 == 0);
            b  = ($urandom % 10 == 0);
            ba = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : $urandom;
            a  = exp_req() && ($urandom % 2 == 0);
            drive(s, f, b, ba, a);
            cycle();
            n_vec++; if (imem_req !== exp_req()) begin n_err++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, exp_req()); end
            if (exp_req()) begin
                n_vec++; if (imem_addr !== exp_addr()) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, exp_addr()); end
            end
            n_vec++; if (if_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, if_valid, m_valid); end
            if (m_valid) begin
                n_vec++; if (if_instr !== m_instr) begin n_err++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, if_instr, m_instr); end
                n_vec++; if (if_pc !== m_ifpc) begin n_err++; $display("FAIL rnd_ifpc[%0d]: got %h want %h", i, if_pc, m_ifpc); end
            end
        end
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 32'h0, 0);
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_branch_drain();
        test_freeze();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL provide ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Stall  input  1  hazard-unit stall; holds PC and IF/ID.
- Freeze  input  1  memory-stage freeze; holds PC and IF/ID, and masks Br_Taken.
- Br_Taken  input  1  EX-stage redirect request.
- Br_Addr  input  32  redirect target.
- Imem_Req  output  1  fetch request.
- Imem_Addr  output  32  fetch address.
- Imem_Ack  input  1  one-cycle completion pulse, valid only while Imem_Req=1.
- Imem_Data  input  32  instruction, valid with Imem_Ack.
- IF_Valid  output  1  IF/ID register holds a real instruction.
- IF_Instr  output  32  IF/ID instruction.
- IF_PC  output  32  IF/ID fetch address + 4.

Function
REQ-004 SHALL define adv = ~Stall & ~Freeze and br = Br_Taken & ~Freeze.
REQ-005 SHALL implement FSM states IDLE, FETCH, HOLD and DRAIN; the reset state SHALL be IDLE, and IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-006 SHALL drive Imem_Req=1 in FETCH and DRAIN, and 0 in IDLE and HOLD.
REQ-007 SHALL drive Imem_Addr with the PC register in FETCH and with the latched in-flight address in DRAIN.
REQ-008 SHALL hold Imem_Addr stable while Imem_Req=1 and Imem_Ack=0.
REQ-009 FETCH, Imem_Ack=1, adv=1, br=0: SHALL load IF/ID with {Imem_Data, PC+4, Valid=1}, set PC<=PC+4, and stay in FETCH.
REQ-010 FETCH, Imem_Ack=1, adv=0, br=0: SHALL capture Imem_Data into the hold buffer, leave IF/ID unchanged, and go to HOLD.
REQ-011 FETCH, Imem_Ack=0, br=0: if adv=1, IF/ID SHALL load a bubble (IF_Valid<=0); if adv=0, IF/ID SHALL hold.
REQ-012 HOLD, adv=1, br=0: SHALL load IF/ID from the hold buffer with {buffer, PC+4, Valid=1}, set PC<=PC+4, and go to FETCH; with adv=0 it SHALL remain in HOLD with no change.
REQ-013 br=1 in FETCH with Imem_Ack=1: SHALL discard Imem_Data, set PC<=Br_Addr, set IF_Valid<=0, and stay in FETCH.
REQ-014 br=1 in FETCH with Imem_Ack=0: SHALL latch the in-flight address, set PC<=Br_Addr, set IF_Valid<=0, and go to DRAIN.
REQ-015 br=1 in HOLD: SHALL discard the hold buffer, set PC<=Br_Addr, set IF_Valid<=0, and go to FETCH.
REQ-016 br=1 in IDLE: SHALL set PC<=Br_Addr and set IF_Valid<=0.
REQ-017 DRAIN: SHALL keep requesting until Imem_Ack, discard the returned data, and then go to FETCH.
REQ-018 br=1 during DRAIN: SHALL overwrite PC with the newest Br_Addr (latest target wins) and set IF_Valid<=0.
REQ-019 Any flush (br=1) SHALL clear IF_Valid regardless of Stall.
REQ-020 Br_Taken with Freeze=1 SHALL be ignored.
REQ-021 Only IF_Valid SHALL change on a flush; IF_Instr and IF_PC may keep stale values while IF_Valid=0.
REQ-022 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000, including IF_PC.
REQ-023 Br_Addr SHALL be used unmodified, with no alignment check.
REQ-024 No more than one Imem request SHALL be outstanding at any time.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, PC=RESET_PC, Imem_Req=0, IF_Valid=0, IF_Instr=0, IF_PC=0, hold buffer=0, and drain address=0.
REQ-026 Reset asserted mid-request SHALL abandon the request; an Imem_Ack arriving after reset release while in IDLE SHALL be ignored.
REQ-027 The first Imem_Req SHALL appear the cycle after the first rising edge following rst_n release.

Verification
REQ-028 Zero-wait memory (Ack the same cycle as Req), Stall=Freeze=Br_Taken=0, RESET_PC=0 -> IF_PC sequence 4, 8, 12, 16 on consecutive cycles, with IF_Valid=1 from the second FETCH cycle.
REQ-029 Ack with Stall=1 for 3 cycles -> state HOLD, Imem_Req=0, IF/ID unchanged for 3 cycles; when Stall drops, the buffered instruction is in IF/ID the next cycle, then fetch resumes at PC+4.
REQ-030 Br_Taken=1, Br_Addr=32'h100, request outstanding with Ack delayed 2 cycles -> IF_Valid=0, DRAIN holds the old Imem_Addr, old data discarded, next Imem_Addr=32'h100.
REQ-031 Br_Taken with Freeze=1 -> no redirect and no flush; the same Br_Taken after Freeze drops -> redirect taken.
REQ-032 RESET_PC=32'hFFFF_FFFC -> first IF_PC=32'h0, next Imem_Addr=32'h0.
REQ-033 rst_n pulsed low while in DRAIN -> all outputs reach reset values asynchronously; a stray Ack in IDLE is ignored.
